// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-control decode, operand forwarding and load-use stall.
// Build option: define IDEX_FORWARD_EN for EX/MEM and MEM/WB forwarding; otherwise RAW hazards stall instead.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hold,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [1:0]    id_alu_op,
    input  logic [5:0]    id_funct,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic          id_alu_src,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic          id_reg_dst,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic          id_mem_to_reg,
    input  logic          id_branch,
    input  logic          exm_reg_write,
    input  logic [RW-1:0] exm_wr_reg,
    input  logic [DW-1:0] exm_result,
    input  logic          mwb_reg_write,
    input  logic [RW-1:0] mwb_wr_reg,
    input  logic [DW-1:0] mwb_result,
    output logic [3:0]    ALU_control,
    output logic [DW-1:0] ALU_operand_1,
    output logic [DW-1:0] ALU_operand_2,
    output logic          ex_valid,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          ex_mem_to_reg,
    output logic          ex_branch,
    output logic [RW-1:0] ex_wr_reg,
    output logic [DW-1:0] ex_store_data,
    output logic          hazard_stall,
    output logic          illegal_funct
);

    logic [1:0]    alu_op_r;
    logic [5:0]    funct_r;
    logic [DW-1:0] rs_data_r;
    logic [DW-1:0] rt_data_r;
    logic [DW-1:0] imm_r;
    logic          alu_src_r;
    logic [RW-1:0] rs_r;
    logic [RW-1:0] rt_r;
    logic          bubble_s;
    logic          update_s;
    logic          load_use_s;
    logic          raw_s;
    logic [DW-1:0] fwd_rs_s;
    logic [DW-1:0] fwd_rt_s;

    function automatic logic funct_legal(input logic [5:0] f);
        case (f)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_legal = 1'b1;
            default:                                               funct_legal = 1'b0;
        endcase
    endfunction

    assign load_use_s = id_valid & ex_valid & ex_mem_read & (ex_wr_reg != {RW{1'b0}}) &
                        ((ex_wr_reg == id_rs) | ((ex_wr_reg == id_rt) & ~id_alu_src));

`ifdef IDEX_FORWARD_EN
    assign raw_s = 1'b0;
`else
    // Without forwarding, any pending producer in EX or EX/MEM must drain first
    assign raw_s = id_valid & (
        (ex_valid & ex_reg_write & (ex_wr_reg != {RW{1'b0}}) &
            ((ex_wr_reg == id_rs) | (ex_wr_reg == id_rt))) |
        (exm_reg_write & (exm_wr_reg != {RW{1'b0}}) &
            ((exm_wr_reg == id_rs) | (exm_wr_reg == id_rt))));
`endif

    assign hazard_stall = load_use_s | raw_s;
    assign bubble_s     = flush | hazard_stall;
    assign update_s     = flush | ~hold;

    // Pipeline register: flush beats hold, hold beats stall-bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_branch     <= 1'b0;
            alu_op_r      <= 2'b00;
            funct_r       <= 6'd0;
            rs_data_r     <= {DW{1'b0}};
            rt_data_r     <= {DW{1'b0}};
            imm_r         <= {DW{1'b0}};
            alu_src_r     <= 1'b0;
            rs_r          <= {RW{1'b0}};
            rt_r          <= {RW{1'b0}};
            ex_wr_reg     <= {RW{1'b0}};
            illegal_funct <= 1'b0;
        end else if (update_s) begin
            ex_valid      <= id_valid      & ~bubble_s;
            ex_reg_write  <= id_reg_write  & ~bubble_s;
            ex_mem_read   <= id_mem_read   & ~bubble_s;
            ex_mem_write  <= id_mem_write  & ~bubble_s;
            ex_mem_to_reg <= id_mem_to_reg & ~bubble_s;
            ex_branch     <= id_branch     & ~bubble_s;
            alu_op_r      <= bubble_s ? 2'b00 : id_alu_op;
            funct_r       <= bubble_s ? 6'd0 : id_funct;
            rs_data_r     <= bubble_s ? {DW{1'b0}} : id_rs_data;
            rt_data_r     <= bubble_s ? {DW{1'b0}} : id_rt_data;
            imm_r         <= bubble_s ? {DW{1'b0}} : id_imm;
            alu_src_r     <= id_alu_src & ~bubble_s;
            rs_r          <= bubble_s ? {RW{1'b0}} : id_rs;
            rt_r          <= bubble_s ? {RW{1'b0}} : id_rt;
            ex_wr_reg     <= bubble_s ? {RW{1'b0}} : (id_reg_dst ? id_rd : id_rt);
            illegal_funct <= ~bubble_s & (id_alu_op == 2'b10) & ~funct_legal(id_funct);
        end
    end

`ifdef IDEX_FORWARD_EN
    // Operand forwarding; EX/MEM is newer than MEM/WB so it wins
    always_comb begin
        fwd_rs_s = rs_data_r;
        fwd_rt_s = rt_data_r;
        if (exm_reg_write && exm_wr_reg != {RW{1'b0}} && exm_wr_reg == rs_r) begin
            fwd_rs_s = exm_result;
        end else if (mwb_reg_write && mwb_wr_reg != {RW{1'b0}} && mwb_wr_reg == rs_r) begin
            fwd_rs_s = mwb_result;
        end else begin
            fwd_rs_s = rs_data_r;
        end
        if (exm_reg_write && exm_wr_reg != {RW{1'b0}} && exm_wr_reg == rt_r) begin
            fwd_rt_s = exm_result;
        end else if (mwb_reg_write && mwb_wr_reg != {RW{1'b0}} && mwb_wr_reg == rt_r) begin
            fwd_rt_s = mwb_result;
        end else begin
            fwd_rt_s = rt_data_r;
        end
    end
`else
    logic unused_fwd_s;
    assign unused_fwd_s = ^{exm_result, mwb_reg_write, mwb_wr_reg, mwb_result, rs_r, rt_r};
    assign fwd_rs_s = rs_data_r;
    assign fwd_rt_s = rt_data_r;
`endif

    // ALU control decode and operand-2 selection from the registered fields
    always_comb begin
        ALU_control   = 4'd2;
        ALU_operand_2 = alu_src_r ? imm_r : fwd_rt_s;
        case (alu_op_r)
            2'b00: ALU_control = 4'd2;
            2'b01: ALU_control = 4'd4;
            2'b11: begin
                ALU_control   = 4'd1;
                ALU_operand_2 = {{(DW-16){1'b0}}, imm_r[15:0]};
            end
            2'b10: begin
                case (funct_r)
                    6'b100000: ALU_control = 4'd2;
                    6'b100010: ALU_control = 4'd6;
                    6'b100100: ALU_control = 4'd0;
                    6'b100101: ALU_control = 4'd1;
                    6'b101010: ALU_control = 4'd7;
                    default:   ALU_control = 4'd2;
                endcase
            end
            default: ALU_control = 4'd2;
        endcase
    end

    assign ALU_operand_1 = fwd_rs_s;
    assign ex_store_data = fwd_rt_s;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; expectations follow IDEX_FORWARD_EN if defined.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int RW = 5;

`ifdef IDEX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n, hold, flush, id_valid;
    logic [1:0]    id_alu_op;
    logic [5:0]    id_funct;
    logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
    logic          id_alu_src;
    logic [RW-1:0] id_rs, id_rt, id_rd;
    logic          id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;
    logic          exm_reg_write;
    logic [RW-1:0] exm_wr_reg;
    logic [DW-1:0] exm_result;
    logic          mwb_reg_write;
    logic [RW-1:0] mwb_wr_reg;
    logic [DW-1:0] mwb_result;
    logic [3:0]    ALU_control;
    logic [DW-1:0] ALU_operand_1, ALU_operand_2, ex_store_data;
    logic          ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;
    logic [RW-1:0] ex_wr_reg;
    logic          hazard_stall, illegal_funct;

    int total_cnt = 0;
    int bad_cnt   = 0;

    id_ex_stage #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_alu_op(id_alu_op), .id_funct(id_funct), .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data), .id_imm(id_imm), .id_alu_src(id_alu_src),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_reg_dst(id_reg_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
        .exm_reg_write(exm_reg_write), .exm_wr_reg(exm_wr_reg), .exm_result(exm_result),
        .mwb_reg_write(mwb_reg_write), .mwb_wr_reg(mwb_wr_reg), .mwb_result(mwb_result),
        .ALU_control(ALU_control), .ALU_operand_1(ALU_operand_1), .ALU_operand_2(ALU_operand_2),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
        .ex_wr_reg(ex_wr_reg), .ex_store_data(ex_store_data),
        .hazard_stall(hazard_stall), .illegal_funct(illegal_funct)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_cnt++;
        if (observed !== expected) begin
            bad_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id_clear();
        id_valid = 1'b0; id_alu_op = 2'b00; id_funct = 6'd0;
        id_rs_data = 32'd0; id_rt_data = 32'd0; id_imm = 32'd0; id_alu_src = 1'b0;
        id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0; id_reg_dst = 1'b0;
        id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
        id_mem_to_reg = 1'b0; id_branch = 1'b0;
    endtask

    task automatic rtype(input logic [5:0] f, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
        id_clear();
        id_valid = 1'b1; id_alu_op = 2'b10; id_funct = f;
        id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = a; id_rt_data = b;
        id_reg_dst = 1'b1; id_reg_write = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
        id_clear();
        exm_reg_write = 1'b0; exm_wr_reg = 5'd0; exm_result = 32'd0;
        mwb_reg_write = 1'b0; mwb_wr_reg = 5'd0; mwb_result = 32'd0;
        #12;
        check_val("rst_valid", {31'd0, ex_valid}, 32'd0);
        check_val("rst_aluctl", {28'd0, ALU_control}, 32'd2);
        check_val("rst_op1", ALU_operand_1, 32'd0);
        check_val("rst_op2", ALU_operand_2, 32'd0);
        check_val("rst_wr_reg", {27'd0, ex_wr_reg}, 32'd0);
        check_val("rst_illegal", {31'd0, illegal_funct}, 32'd0);
        rst_n = 1'b1;
        tick();

        // R-type sub
        rtype(6'b100010, 5'd1, 5'd2, 5'd10, 32'd9, 32'd4);
        tick();
        check_val("sub_aluctl", {28'd0, ALU_control}, 32'd6);
        check_val("sub_op1", ALU_operand_1, 32'd9);
        check_val("sub_op2", ALU_operand_2, 32'd4);
        check_val("sub_wr_reg", {27'd0, ex_wr_reg}, 32'd10);
        check_val("sub_valid", {30'd0, ex_valid, ex_reg_write}, 32'd3);

        // Forwarding priority on rs=3 / rt=4
        id_clear();
        id_valid = 1'b1; id_rs = 5'd3; id_rt = 5'd4; id_rd = 5'd11;
        id_rs_data = 32'h55; id_rt_data = 32'h66; id_reg_dst = 1'b1; id_reg_write = 1'b1;
        tick();
        id_clear();
        exm_reg_write = 1'b1; exm_wr_reg = 5'd3; exm_result = 32'h11;
        mwb_reg_write = 1'b1; mwb_wr_reg = 5'd3; mwb_result = 32'h22;
        #1;
        check_val("fwd_exm_wins", ALU_operand_1, FWD ? 32'h11 : 32'h55);
        exm_wr_reg = 5'd0;
        #1;
        check_val("fwd_mwb", ALU_operand_1, FWD ? 32'h22 : 32'h55);
        mwb_wr_reg = 5'd4;
        #1;
        check_val("fwd_rt_op1", ALU_operand_1, 32'h55);
        check_val("fwd_rt_store", ex_store_data, FWD ? 32'h22 : 32'h66);
        check_val("fwd_rt_op2", ALU_operand_2, FWD ? 32'h22 : 32'h66);
        exm_reg_write = 1'b0; mwb_reg_write = 1'b0; mwb_wr_reg = 5'd0;

        // Load-use: lw r5 in EX, add using r5 in ID
        id_clear();
        id_valid = 1'b1; id_mem_read = 1'b1; id_reg_write = 1'b1; id_mem_to_reg = 1'b1;
        id_alu_src = 1'b1; id_rs = 5'd1; id_rt = 5'd5; id_imm = 32'd4;
        tick();
        check_val("lw_wr_reg", {27'd0, ex_wr_reg}, 32'd5);
        check_val("lw_op2_imm", ALU_operand_2, 32'd4);
        rtype(6'b100000, 5'd5, 5'd6, 5'd7, 32'd20, 32'd30);
        #1;
        check_val("lu_stall", {31'd0, hazard_stall}, 32'd1);
        tick();
        check_val("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        check_val("lu_bubble_aluctl", {28'd0, ALU_control}, 32'd2);
        check_val("lu_bubble_ctl", {28'd0, ex_reg_write, ex_mem_read, ex_mem_to_reg, ex_branch}, 32'd0);
        check_val("lu_stall_clear", {31'd0, hazard_stall}, 32'd0);
        tick();
        check_val("add_valid", {31'd0, ex_valid}, 32'd1);
        check_val("add_wr_reg", {27'd0, ex_wr_reg}, 32'd7);
        check_val("add_op1", ALU_operand_1, 32'd20);

        // Non-load RAW: stalls only without forwarding; register 0 never stalls
        id_clear(); id_valid = 1'b1; id_rs = 5'd7;
        #1;
        check_val("raw_ex", {31'd0, hazard_stall}, {31'd0, ~FWD});
        id_rs = 5'd9; exm_reg_write = 1'b1; exm_wr_reg = 5'd9;
        #1;
        check_val("raw_exm", {31'd0, hazard_stall}, {31'd0, ~FWD});
        id_rs = 5'd0; exm_wr_reg = 5'd0;
        #1;
        check_val("raw_r0", {31'd0, hazard_stall}, 32'd0);
        exm_reg_write = 1'b0;

        // flush + hold loads a bubble
        rtype(6'b100000, 5'd12, 5'd13, 5'd14, 32'd1, 32'd2);
        flush = 1'b1; hold = 1'b1;
        tick();
        check_val("flush_hold_valid", {31'd0, ex_valid}, 32'd0);
        check_val("flush_hold_wr", {27'd0, ex_wr_reg}, 32'd0);
        flush = 1'b0; hold = 1'b0;
        rtype(6'b100100, 5'd12, 5'd13, 5'd8, 32'hF0, 32'h3C);
        tick();
        check_val("and_aluctl", {28'd0, ALU_control}, 32'd0);
        hold = 1'b1;
        rtype(6'b100101, 5'd8, 5'd2, 5'd9, 32'd1, 32'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("hold_aluctl", {28'd0, ALU_control}, 32'd0);
            check_val("hold_op1", ALU_operand_1, 32'hF0);
            check_val("hold_wr", {27'd0, ex_wr_reg}, 32'd8);
        end
        hold = 1'b0;

        // Illegal funct, ori, slt, beq
        rtype(6'b000111, 5'd1, 5'd2, 5'd14, 32'd1, 32'd2);
        tick();
        check_val("ill_aluctl", {28'd0, ALU_control}, 32'd2);
        check_val("ill_flag", {31'd0, illegal_funct}, 32'd1);
        id_clear();
        id_valid = 1'b1; id_alu_op = 2'b11; id_alu_src = 1'b1; id_imm = 32'hFFFF8000;
        id_rs = 5'd1; id_rt = 5'd15; id_rs_data = 32'd1; id_reg_write = 1'b1;
        tick();
        check_val("ori_aluctl", {28'd0, ALU_control}, 32'd1);
        check_val("ori_op2", ALU_operand_2, 32'h00008000);
        check_val("ori_illegal", {31'd0, illegal_funct}, 32'd0);
        check_val("ori_wr_reg", {27'd0, ex_wr_reg}, 32'd15);
        rtype(6'b101010, 5'd1, 5'd2, 5'd16, 32'd3, 32'd4);
        tick();
        check_val("slt_aluctl", {28'd0, ALU_control}, 32'd7);
        id_clear();
        id_valid = 1'b1; id_alu_op = 2'b01; id_branch = 1'b1; id_rs = 5'd1; id_rt = 5'd2;
        id_rs_data = 32'd5; id_rt_data = 32'd5;
        tick();
        check_val("beq_aluctl", {28'd0, ALU_control}, 32'd4);
        check_val("beq_branch", {31'd0, ex_branch}, 32'd1);

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("arst_valid", {31'd0, ex_valid}, 32'd0);
        check_val("arst_aluctl", {28'd0, ALU_control}, 32'd2);
        check_val("arst_op1", ALU_operand_1, 32'd0);
        check_val("arst_op2", ALU_operand_2, 32'd0);
        tick();
        check_val("arst_hold_valid", {31'd0, ex_valid}, 32'd0);
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
